// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, RV32I opcodes,
// ALU operation codes and datapath mux selects.
package ctrl_pkg;

    typedef enum logic [2:0] {
        StPrepare,
        StFetch,
        StLoadIr,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    typedef enum logic [2:0] {
        ClsR,
        ClsIAlu,
        ClsLoad,
        ClsStore,
        ClsBranch,
        ClsJal
    } instr_cls_e;

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcIAlu   = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;

    localparam logic [6:0] Funct7Base = 7'b0000000;
    localparam logic [6:0] Funct7Alt  = 7'b0100000;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluSll  = 4'd5;
    localparam logic [3:0] AluSrl  = 4'd6;
    localparam logic [3:0] AluSra  = 4'd7;
    localparam logic [3:0] AluSlt  = 4'd8;
    localparam logic [3:0] AluSltu = 4'd9;

    localparam logic [1:0] Op2Rs2  = 2'd0;
    localparam logic [1:0] Op2ImmI = 2'd1;
    localparam logic [1:0] Op2ImmS = 2'd2;

    localparam logic [1:0] RegInAlu = 2'd0;
    localparam logic [1:0] RegInRam = 2'd1;
    localparam logic [1:0] RegInPc4 = 2'd2;

    // alt selects SUB/SRA over ADD/SRL (funct7 bit 5 / instr[30]).
    function automatic logic [3:0] alu_op_of(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = alt ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: classifies the IR, selects the ALU
// operation and operand-2 source, and flags unsupported encodings.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [3:0] alu_op_o,
    output logic [1:0] op2_dir_o,
    output logic [2:0] cls_o,
    output logic       illegal_o
);

    always_comb begin
        alu_op_o  = AluAdd;
        op2_dir_o = Op2Rs2;
        cls_o     = ClsR;
        illegal_o = 1'b0;

        case (opcode_i)
            OpcR: begin
                cls_o = ClsR;
                if (funct7_i == Funct7Base) begin
                    alu_op_o = alu_op_of(funct3_i, 1'b0);
                end else if (funct7_i == Funct7Alt &&
                             (funct3_i == 3'b000 || funct3_i == 3'b101)) begin
                    alu_op_o = alu_op_of(funct3_i, 1'b1);
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OpcIAlu: begin
                cls_o     = ClsIAlu;
                op2_dir_o = Op2ImmI;
                // Only the shift-immediates constrain funct7; no SUBI exists.
                if (funct3_i == 3'b001) begin
                    alu_op_o  = AluSll;
                    illegal_o = (funct7_i != Funct7Base);
                end else if (funct3_i == 3'b101) begin
                    alu_op_o  = (funct7_i == Funct7Alt) ? AluSra : AluSrl;
                    illegal_o = (funct7_i != Funct7Base) && (funct7_i != Funct7Alt);
                end else begin
                    alu_op_o = alu_op_of(funct3_i, 1'b0);
                end
            end
            OpcLoad: begin
                cls_o     = ClsLoad;
                op2_dir_o = Op2ImmI;
                illegal_o = (funct3_i != 3'b010);
            end
            OpcStore: begin
                cls_o     = ClsStore;
                op2_dir_o = Op2ImmS;
                illegal_o = (funct3_i != 3'b010);
            end
            OpcBranch: begin
                cls_o     = ClsBranch;
                alu_op_o  = AluSub;
                illegal_o = (funct3_i != 3'b000) && (funct3_i != 3'b001);
            end
            OpcJal: begin
                cls_o = ClsJal;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: FSM sequencing fetch/decode/execute/memory/write-back
// with RAM accesses stretched to MEM_LAT cycles by a wait counter.
module mc_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned ALU_OP_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                alu_zero,
    output logic                ram_cs,
    output logic                ram_we,
    output logic                ram_oe,
    output logic                ram_addr_dir,
    output logic                pc_en,
    output logic                pc_in_dir,
    output logic                pc_sign,
    output logic                ir_en,
    output logic                reg_en,
    output logic                reg_we,
    output logic [1:0]          reg_in_dir,
    output logic                alu_en,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          op2_dir,
    output logic                halted
);

    localparam int unsigned CntW = $clog2(MEM_LAT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(MEM_LAT - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            cnt_last;

    logic [3:0] dec_alu_op;
    logic [1:0] dec_op2_dir;
    logic [2:0] dec_cls;
    logic       dec_illegal;
    logic       take_pc;

    // Register fields are consumed by the datapath, not by the controller.
    logic unused_instr;
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    ctrl_decode u_decode (
        .opcode_i  (instr[6:0]),
        .funct3_i  (instr[14:12]),
        .funct7_i  (instr[31:25]),
        .alu_op_o  (dec_alu_op),
        .op2_dir_o (dec_op2_dir),
        .cls_o     (dec_cls),
        .illegal_o (dec_illegal)
    );

    assign cnt_last = (cnt_q == CntLast);

    assign take_pc = (dec_cls == ClsJal) ||
                     ((dec_cls == ClsBranch) && (instr[12] ? !alu_zero : alu_zero));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StPrepare;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StPrepare: begin
                state_d = StFetch;
                cnt_d   = '0;
            end
            StFetch: begin
                if (cnt_last) begin
                    state_d = StLoadIr;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StLoadIr: state_d = StDecode;
            StDecode: state_d = dec_illegal ? StHalt : StExec;
            StExec: begin
                cnt_d = '0;
                if (dec_cls == ClsLoad || dec_cls == ClsStore) begin
                    state_d = StMem;
                end else if (dec_cls == ClsBranch) begin
                    state_d = StFetch;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (cnt_last) begin
                    state_d = (dec_cls == ClsLoad) ? StWb : StFetch;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWb: begin
                state_d = StFetch;
                cnt_d   = '0;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StPrepare;
        endcase
    end

    // Gating on rst drops every strobe in the same cycle reset is raised.
    always_comb begin
        ram_cs       = 1'b0;
        ram_we       = 1'b0;
        ram_oe       = 1'b0;
        ram_addr_dir = 1'b0;
        pc_en        = 1'b0;
        pc_in_dir    = 1'b0;
        pc_sign      = 1'b0;
        ir_en        = 1'b0;
        reg_en       = 1'b0;
        reg_we       = 1'b0;
        reg_in_dir   = RegInAlu;
        alu_en       = 1'b0;
        alu_op       = '0;
        op2_dir      = Op2Rs2;
        halted       = 1'b0;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    ram_cs = 1'b1;
                    ram_oe = 1'b1;
                    pc_en  = cnt_last;
                end
                StLoadIr: ir_en = 1'b1;
                StExec: begin
                    alu_en  = 1'b1;
                    reg_en  = 1'b1;
                    alu_op  = ALU_OP_W'(dec_alu_op);
                    op2_dir = dec_op2_dir;
                    if (take_pc) begin
                        pc_en     = 1'b1;
                        pc_in_dir = 1'b1;
                        pc_sign   = instr[31];
                    end
                end
                StMem: begin
                    ram_cs       = 1'b1;
                    ram_addr_dir = 1'b1;
                    ram_oe       = (dec_cls == ClsLoad);
                    ram_we       = (dec_cls == ClsStore);
                end
                StWb: begin
                    reg_en = 1'b1;
                    reg_we = 1'b1;
                    if (dec_cls == ClsLoad) begin
                        reg_in_dir = RegInRam;
                    end else if (dec_cls == ClsJal) begin
                        reg_in_dir = RegInPc4;
                    end
                end
                StHalt:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
